// File: rtl/adc_recepcion_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_recepcion_pkg
// Purpose  : Shared types and constants for the serial ADC frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
package adc_recepcion_pkg;

  // Serial bits per conversion frame: 4 leading zeros plus 12 data bits.
  localparam int FRAME_BITS = 16;
  // Significant LSBs of the frame that form the sample.
  localparam int DATA_BITS  = 12;
  // Bit counter width; must cover FRAME_BITS-1.
  localparam int CNT_W      = 4;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : adc_recepcion_pkg
`default_nettype wire

// File: rtl/adc_recepcion.sv
`default_nettype none
// ============================================================================
// Module   : adc_recepcion
// Purpose  : Receiver for a 12-bit SPI-style ADC (AD7476 / PmodAD1 class).
//            Runs directly on SCLK, shifts in a 16-bit MSB-first frame and
//            exposes the raw frame, the 12-bit sample and a done tick.
// Revision : 1.0 - initial release
// ============================================================================
module adc_recepcion #(
  parameter int FRAME_BITS = adc_recepcion_pkg::FRAME_BITS,
  parameter int DATA_BITS  = adc_recepcion_pkg::DATA_BITS
) (
  input  logic                  SCLK,
  input  logic                  reset,
  input  logic                  ADCdata,
  input  logic                  rx_en,
  output logic                  rx_done_tick,
  output logic [FRAME_BITS-1:0] b_reg,
  output logic [DATA_BITS-1:0]  data_out
);

  import adc_recepcion_pkg::*;

  // Counter value on the edge that captures the last bit of the frame.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;

  // Frame FSM: sequences start edge, 16 sample edges and one gap cycle.
  // rx_en is only looked at in IDLE and DONE, so a started frame always
  // completes even if the enable is withdrawn part-way through.
  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      b_reg    <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ADCdata on this edge is deliberately not captured.
          if (rx_en) begin
            state   <= RECV;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          b_reg <= {b_reg[FRAME_BITS-2:0], ADCdata};
          if (bit_cnt == LAST_BIT) begin
            // Take the sample straight from the incoming bits so data_out
            // matches b_reg[11:0] in the same cycle the tick is raised.
            data_out <= {b_reg[DATA_BITS-2:0], ADCdata};
            state    <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          // Inter-frame gap: one cycle with no shifting.
          bit_cnt <= '0;
          if (rx_en) begin
            state <= RECV;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Decoded from the state register alone, so the tick is glitch-free
  // and exactly one SCLK period wide.
  assign rx_done_tick = (state == DONE);

endmodule : adc_recepcion
`default_nettype wire

// File: tb/tb_adc_recepcion.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_recepcion
// Purpose  : Self-checking bench for adc_recepcion with a frame scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_recepcion;

  logic        SCLK;
  logic        reset;
  logic        ADCdata;
  logic        rx_en;
  logic        rx_done_tick;
  logic [15:0] b_reg;
  logic [11:0] data_out;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tick_count = 0;
  int          rel_cyc = 0;
  int          ticks_before = 0;
  logic        prev_tick = 1'b0;
  logic [11:0] model_data = '0;
  logic [15:0] exp_q[$];
  int          tick_cycles[$];

  adc_recepcion #(
    .FRAME_BITS(16),
    .DATA_BITS (12)
  ) dut (
    .SCLK        (SCLK),
    .reset       (reset),
    .ADCdata     (ADCdata),
    .rx_en       (rx_en),
    .rx_done_tick(rx_done_tick),
    .b_reg       (b_reg),
    .data_out    (data_out)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  // Rising-edge counter used for tick timing.
  always @(posedge SCLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: samples 2 time units after each rising edge, pops the
  // scoreboard on every tick and verifies data_out holds between ticks.
  always @(posedge SCLK) begin
    logic [15:0] e;
    #2;
    if (!reset) model_data = '0;
    if (rx_done_tick) begin
      tick_cycles.push_back(cyc);
      tick_count++;
      check("tick_width", 32'(prev_tick), 32'd0);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_b_reg", 32'(b_reg), 32'(e));
        check("sb_data_out", 32'(data_out), 32'(e[11:0]));
        model_data = e[11:0];
      end
    end else begin
      check("data_hold", 32'(data_out), 32'(model_data));
    end
    prev_tick = rx_done_tick;
  end

  // Drives one frame MSB first on falling edges, then one gap half-cycle.
  task automatic send_frame(input logic [15:0] f, input int drop_after, input bit last);
    exp_q.push_back(f);
    for (int i = 15; i >= 0; i--) begin
      @(negedge SCLK);
      ADCdata = f[i];
      if ((16 - i) == drop_after) rx_en = 1'b0;
    end
    @(negedge SCLK);
    ADCdata = 1'($urandom_range(0, 1));
    if (last) rx_en = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    rx_en   = 1'b1;
    ADCdata = 1'b0;

    // Reset held with toggling data: everything stays cleared.
    for (int k = 0; k < 5; k++) begin
      @(negedge SCLK);
      ADCdata = ~ADCdata;
      @(posedge SCLK);
      #2;
      check("rst_b_reg", 32'(b_reg), 32'h0);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_tick", 32'(rx_done_tick), 32'h0);
    end

    // Single frame 0x0AC3 right after release, then back-to-back frames.
    @(negedge SCLK);
    reset   = 1'b1;
    rx_en   = 1'b1;
    rel_cyc = cyc;
    send_frame(16'h0AC3, -1, 1'b0);
    send_frame(16'h0FFF, -1, 1'b0);
    send_frame(16'h0001, -1, 1'b1);
    check("ticks_after_b2b", 32'(tick_count), 32'd3);
    if (tick_cycles.size() >= 3) begin
      check("first_tick_latency", 32'(tick_cycles[0] - rel_cyc), 32'd17);
      check("b2b_period_1", 32'(tick_cycles[1] - tick_cycles[0]), 32'd17);
      check("b2b_period_2", 32'(tick_cycles[2] - tick_cycles[1]), 32'd17);
    end
    repeat (3) @(negedge SCLK);

    // rx_en dropped after bit 5: frame still completes, then FSM idles.
    ticks_before = tick_count;
    rx_en = 1'b1;
    send_frame(16'h0555, 5, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge SCLK);
      #2;
      check("idle_b_reg_hold", 32'(b_reg), 32'h0555);
    end
    check("drop_single_tick", 32'(tick_count - ticks_before), 32'd1);

    // Reset asserted after 8 bits of a frame: immediate clear, no tick.
    @(negedge SCLK);
    ticks_before = tick_count;
    rx_en = 1'b1;
    for (int i = 15; i >= 8; i--) begin
      @(negedge SCLK);
      ADCdata = i[0];
    end
    @(negedge SCLK);
    reset = 1'b0;
    #1;
    check("abort_b_reg", 32'(b_reg), 32'h0);
    check("abort_data_out", 32'(data_out), 32'h0);
    check("abort_tick", 32'(rx_done_tick), 32'h0);
    repeat (2) @(negedge SCLK);
    check("abort_no_tick", 32'(tick_count - ticks_before), 32'd0);

    // Next frame after release, with a nonzero header.
    reset   = 1'b1;
    rx_en   = 1'b1;
    rel_cyc = cyc;
    send_frame(16'hF123, -1, 1'b1);
    check("post_abort_tick", 32'(tick_count - ticks_before), 32'd1);
    if (tick_cycles.size() >= 5)
      check("post_abort_latency", 32'(tick_cycles[4] - rel_cyc), 32'd17);
    repeat (4) @(posedge SCLK);
    #2;
    check("final_b_reg", 32'(b_reg), 32'hF123);
    check("final_data_out", 32'(data_out), 32'h123);
    check("final_tick_count", 32'(tick_count), 32'd5);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule : tb_adc_recepcion
`default_nettype wire
